// File: rtl/clock_pkg.sv
// clock_pkg: shared types and default parameters for the clock input path
package clock_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} rpt_state_t;
    typedef enum logic [1:0] {HOURS, MINUTES, CLOCK} mode_t;
    localparam int TICK_DIV_DEF     = 1000;
    localparam int DB_TICKS_DEF     = 2;
    localparam int REPEAT_DELAY_DEF = 50;
    localparam int REPEAT_RATE_DEF  = 10;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a tick-sampled debouncer
module btn_debounce import clock_pkg::*; #(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pb,
    output logic level,
    output logic level_nx
);
    localparam int CW = cnt_w(DB_TICKS);
    logic [1:0]    sync_q, sync_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // level_nx exposes the flip in the same cycle as the qualifying tick
    always_comb begin
        sync_d = {sync_q[0], pb};
        db_d   = db_q;
        cnt_d  = cnt_q;
        if (sync_q[1] == db_q)
            cnt_d = '0;
        else if (tick) begin
            if (cnt_q == CW'(DB_TICKS - 1)) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else
                cnt_d = cnt_q + CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end
    assign level    = db_q;
    assign level_nx = db_d;
endmodule

// File: rtl/clock_input_ctrl.sv
// clock_input_ctrl: tick prescaler, button conditioning and inc/dec auto-repeat
module clock_input_ctrl import clock_pkg::*; #(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int DB_TICKS     = DB_TICKS_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_state,
    input  logic pb_inc,
    input  logic pb_dec,
    output logic tick,
    output logic state,
    output logic inc,
    output logic dec,
    output logic held
);
    localparam int PW = cnt_w(TICK_DIV);
    localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    logic [PW-1:0] pre_q, pre_d;
    logic [RW-1:0] rcnt_q, rcnt_d, limit;
    rpt_state_t    rs_q, rs_d;
    logic          tick_q, tick_d, state_q, state_d, inc_q, inc_d, dec_q, dec_d, held_q, held_d;
    logic          dir_q, dir_d, fire, own, other;
    logic          st_l, st_nx, inc_l, inc_nx, dec_l, dec_nx, inc_r, dec_r;
    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_state (
        .clk(clk), .reset(reset), .tick(tick_q), .pb(pb_state), .level(st_l), .level_nx(st_nx)
    );
    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_inc (
        .clk(clk), .reset(reset), .tick(tick_q), .pb(pb_inc), .level(inc_l), .level_nx(inc_nx)
    );
    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_dec (
        .clk(clk), .reset(reset), .tick(tick_q), .pb(pb_dec), .level(dec_l), .level_nx(dec_nx)
    );
    assign inc_r = inc_nx & ~inc_l;
    assign dec_r = dec_nx & ~dec_l;
    // tick is registered one count early so it is high while pre_q == TICK_DIV-1
    always_comb begin
        pre_d   = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
        tick_d  = (pre_q == PW'(TICK_DIV - 2));
        state_d = st_nx & ~st_l;
    end
    always_comb begin
        rs_d   = rs_q;
        dir_d  = dir_q;
        rcnt_d = rcnt_q;
        fire   = 1'b0;
        own    = dir_q ? dec_nx : inc_nx;
        other  = dir_q ? inc_nx : dec_nx;
        limit  = (rs_q == DELAY) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);
        case (rs_q)
            IDLE: if (inc_r | dec_r) begin
                if (inc_nx & dec_nx)
                    rs_d = LOCK;
                else begin
                    fire   = 1'b1;
                    dir_d  = dec_r;
                    rcnt_d = '0;
                    rs_d   = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!own)
                    rs_d = IDLE;
                else if (other)
                    rs_d = LOCK;
                else if (tick_q) begin
                    if (rcnt_q == limit) begin
                        fire   = 1'b1;
                        rcnt_d = '0;
                        rs_d   = REPEAT;
                    end else
                        rcnt_d = rcnt_q + RW'(1);
                end
            end
            LOCK: if (!inc_nx && !dec_nx) rs_d = IDLE;
            default: rs_d = IDLE;
        endcase
        inc_d  = fire & ~dir_d;
        dec_d  = fire & dir_d;
        held_d = (rs_d == DELAY) || (rs_d == REPEAT);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            held_q  <= 1'b0;
            rs_q    <= IDLE;
            dir_q   <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            held_q  <= held_d;
            rs_q    <= rs_d;
            dir_q   <= dir_d;
            rcnt_q  <= rcnt_d;
        end
    end
    assign tick  = tick_q;
    assign state = state_q;
    assign inc   = inc_q;
    assign dec   = dec_q;
    assign held  = held_q;
endmodule

// File: tb/tb_clock_input_ctrl.sv
// tb_clock_input_ctrl: table-driven press scenarios with a pulse scoreboard
module tb_clock_input_ctrl;
    localparam int TD = 4, DB = 2, RD = 5, RR = 2;
    logic clk = 1'b0, reset = 1'b1, pb_state = 1'b0, pb_inc = 1'b0, pb_dec = 1'b0;
    logic tick, state, inc, dec, held;
    clock_input_ctrl #(.TICK_DIV(TD), .DB_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .reset(reset), .pb_state(pb_state), .pb_inc(pb_inc), .pb_dec(pb_dec),
        .tick(tick), .state(state), .inc(inc), .dec(dec), .held(held)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
    typedef struct {int kind; int cyc;} evt_t;
    typedef struct {logic [2:0] pb; int hold; int n_s; int n_i; int n_d;} vec_t;
    evt_t exp_q[$];
    vec_t vecs[7];
    int compared = 0, mismatched = 0;
    int obs[3] = '{0, 0, 0};
    int hlo = 1 << 30, hhi = -1;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // kind: 0=state 1=inc 2=dec
    task automatic got(input int kind);
        evt_t e;
        obs[kind]++;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL pulse actual kind=%0d cyc=%0d required=none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                mismatched++;
                $display("FAIL pulse actual kind=%0d cyc=%0d required kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (mon_on) begin
            chk("tick", int'(tick), int'(cyc % TD == TD - 1));
            chk("held", int'(held), int'(cyc >= hlo && cyc <= hhi));
            chk("inc_dec_excl", int'(inc & dec), 0);
            if (state) got(0);
            if (inc) got(1);
            if (dec) got(2);
        end
        #1;
    endtask

    // cycle of the DB-th tick after an input change driven in cycle c
    function automatic int db_tick(input int c);
        int t = c + 2;
        while (t % TD != TD - 1) t++;
        return t + TD * (DB - 1);
    endfunction

    task automatic expect_press(input logic [2:0] pb, input int c, input int r, output int t_rise);
        int t, rel, p;
        t = db_tick(c);
        rel = db_tick(r);
        t_rise = t;
        if (pb[2]) exp_q.push_back('{0, t + 1});
        if (pb[1] ^ pb[0]) begin
            hlo = t + 1;
            hhi = rel;
            p = t + 1;
            while (p <= rel) begin
                exp_q.push_back('{pb[1] ? 1 : 2, p});
                p += (p == t + 1) ? TD * RD : TD * RR;
            end
        end else begin
            hlo = 1 << 30;
            hhi = -1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, b;
        vecs[0] = '{3'b100, 30, 1, 0, 0};
        vecs[1] = '{3'b010, 80, 0, 9, 0};
        vecs[2] = '{3'b001, 24, 0, 0, 2};
        vecs[3] = '{3'b001, 20, 0, 0, 1};
        vecs[4] = '{3'b011, 40, 0, 0, 0};
        vecs[5] = '{3'b001,  8, 0, 0, 1};
        vecs[6] = '{3'b110, 40, 1, 4, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        mon_on = 1'b1;
        chk("reset_outputs", int'({tick, state, inc, dec, held}), 0);
        reset = 1'b0;
        repeat (40) step();
        for (int i = 0; i < 7; i++) begin
            int base[3];
            int c;
            base = obs;
            c = cyc;
            {pb_state, pb_inc, pb_dec} = vecs[i].pb;
            expect_press(vecs[i].pb, c, c + vecs[i].hold, t);
            repeat (vecs[i].hold) step();
            {pb_state, pb_inc, pb_dec} = 3'b000;
            repeat (30) step();
            chk("n_state", obs[0] - base[0], vecs[i].n_s);
            chk("n_inc", obs[1] - base[1], vecs[i].n_i);
            chk("n_dec", obs[2] - base[2], vecs[i].n_d);
            chk("queue_left", exp_q.size(), 0);
            hlo = 1 << 30;
            hhi = -1;
        end
        b = obs[2];
        repeat (5) begin
            pb_dec = 1'b1;
            repeat (3) step();
            pb_dec = 1'b0;
            step();
        end
        repeat (20) step();
        chk("glitch_dec", obs[2] - b, 0);
        b = obs[1];
        pb_inc = 1'b1;
        expect_press(3'b010, cyc, cyc + 200, t);
        while (cyc < t + 1 + TD * RD + 3) step();
        chk("mid_inc_count", obs[1] - b, 2);
        reset = 1'b1;
        exp_q.delete();
        expect_press(3'b010, 0, 16, t);
        b = obs[1];
        step();
        chk("post_reset_outputs", int'({tick, state, inc, dec, held}), 0);
        reset = 1'b0;
        repeat (16) step();
        pb_inc = 1'b0;
        repeat (30) step();
        chk("fresh_inc_count", obs[1] - b, 1);
        chk("queue_left_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/clock_input_ctrl.md
# clock_input_ctrl

Input sequencer for the 24-hour clock datapath. It divides `clk` into a centisecond `tick` that enables the clock counter. It debounces pushbuttons pb6/pb5/pb4 and turns them into the single-cycle `state`, `inc` and `dec` pulses the clock datapath expects, with auto-repeat on inc/dec while a button is held. It sits between the raw pushbutton inputs and the clock/set datapath, and is the only source of those control pulses.

## Interface
- `TICK_DIV`, default 1000: `clk` cycles per `tick`; must be ≥ 2.
- `DB_TICKS`, default 2: number of consecutive ticks a synchronized button level must hold before the debounced level changes.
- `REPEAT_DELAY`, default 50: ticks from the first inc/dec pulse to the first repeat pulse.
- `REPEAT_RATE`, default 10: ticks between repeat pulses.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  active-high reset, synchronous to `clk`. One clock; reset is synchronous and active-high.
- `pb_state`  in  1  raw pb6, asynchronous.
- `pb_inc`  in  1  raw pb5, asynchronous.
- `pb_dec`  in  1  raw pb4, asynchronous.
- `tick`  out  1  one-cycle pulse every `TICK_DIV` cycles; the clock datapath's advance enable.
- `state`  out  1  one-cycle pulse per debounced pb6 press.
- `inc`  out  1  one-cycle increment pulse, with auto-repeat.
- `dec`  out  1  one-cycle decrement pulse, with auto-repeat.
- `held`  out  1  high while the repeat FSM is in DELAY or REPEAT.

## Operation
**Prescaler**
- Counter runs 0..`TICK_DIV`-1 and wraps to 0.
- `tick` is high for the cycle in which count == `TICK_DIV`-1.

**Input conditioning** (per button)
- 2-flop synchronizer, then debouncer.
- Debounced level flips only after the synchronized value has differed from it on `DB_TICKS` consecutive `tick` cycles.
- Any agreeing sample clears the count.

**state**
- Pulses for one cycle after the debounced pb6 rises.
- No repeat; release produces nothing.

**Repeat FSM** (inc/dec). States: IDLE, DELAY, REPEAT, LOCK. Direction register `dir`. Rise detection uses debounced levels.
- IDLE, exactly one of inc/dec rises: pulse that output once, latch `dir`, clear the tick counter, go to DELAY.
- IDLE, both rise in the same cycle: no pulse, go to LOCK.
- DELAY: count ticks. At `REPEAT_DELAY`, pulse `dir` output, clear the count, go to REPEAT.
- REPEAT: pulse `dir` output every `REPEAT_RATE` ticks.
- DELAY/REPEAT: if the `dir` button releases, go to IDLE with no pulse.
- DELAY/REPEAT: if the other button becomes pressed, go to LOCK with no pulse.
- LOCK: stay until both debounced levels are low, then go to IDLE.

**Output rules**
- `inc` and `dec` are never high in the same cycle.
- `state` is independent of `inc` and `dec` and may coincide with either.
- Counters saturate/reset as above; no wrap-around is visible at the outputs.

## Timing
**Reset**
- All outputs 0, FSM = IDLE, all counters 0, debounced levels 0, synchronizers 0.
- Reset asserted mid-repeat: no pulse in the reset cycle or the following cycle.

**Latency**
- `tick` first asserts at cycle `TICK_DIV`-1 after reset deassertion; period is exactly `TICK_DIV` cycles.
- Press latency: 2 sync cycles, then the `DB_TICKS`-th qualifying tick updates the debounced level, then `state`/`inc`/`dec` is registered one cycle later.
- All outputs are registered.

**Repeat pulse alignment**
- Repeat pulses occur exactly one cycle after the qualifying `tick`.
- Spacing in DELAY/REPEAT is `REPEAT_DELAY` and `REPEAT_RATE` ticks respectively, counted from the tick following the previous pulse.

**Release during a pulse cycle**
- The pulse already registered still completes.

## Structure
- Shared package `clock_pkg`:
  - `rpt_state_t` enum {IDLE, DELAY, REPEAT, LOCK}.
  - Default parameter constants.
  - `mode_t` (HOURS, MINUTES, CLOCK) for consumers.
- Sub-module `btn_debounce` (sync + debounce, params `DB_TICKS`), instantiated three times.
- Prescaler and repeat FSM live in the top module.

## Test plan
Bench parameters: `TICK_DIV`=4, `DB_TICKS`=2, `REPEAT_DELAY`=5, `REPEAT_RATE`=2.
- **Reset, then idle 40 cycles** -> `tick` pulses at cycles 3, 7, 11, …; all other outputs 0.
- **pb_state held high 30 cycles, then released** -> exactly one `state` pulse, one cycle after the 2nd qualifying tick; nothing on release.
- **pb_inc held 80 cycles** -> first `inc` pulse, then next `inc` 20 cycles later, then `inc` every 8 cycles; `dec` stays 0; `held`=1 from the first pulse until release.
- **pb_dec glitch** (high 3 cycles, low, repeated 5 times) -> no `dec` pulse.
- **pb_inc and pb_dec asserted together** -> no pulses; FSM in LOCK. Release both, then press pb_dec -> exactly one `dec` pulse.
- **Reset asserted during REPEAT of pb_inc** -> outputs 0 the next cycle. With pb_inc still held after reset, a fresh debounced press produces one `inc` pulse.
